// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C transaction arbiter.
package i2c_pkg;
   localparam int NUM_REQ = 2;
   localparam int RW_BIT = 0;
   typedef enum logic [3:0] {
      S_IDLE, S_GRANT, S_START, S_ADDR, S_NBYTES, S_WDATA, S_RDATA, S_DONE, S_ERR
   } state_t;
   function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; after every taken grant the loser gets priority.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);
   logic prio;
   always_comb gnt = (prio ? req[1] : !req[0]) ? {req[1], 1'b0} : {1'b0, req[0]};
   always_ff @(posedge clk or posedge rst)
      if (rst) prio <= 1'b0;
      else if (take && |gnt) prio <= gnt[0];
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C master between two requesters, sequencing
// start/addr/nbytes/data streams for the granted descriptor with a per-handshake watchdog.
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int DATA_DEPTH    = 8,
   parameter int TIMEOUT_LIMIT = 4096,
   parameter int TIMEOUT_BITS  = 13
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [1:0]              i_req,
   input  logic [2*DATA_DEPTH-1:0] i_req_addr,
   input  logic [2*DATA_DEPTH-1:0] i_req_wdata,
   input  logic [2*DATA_DEPTH-1:0] i_req_nbytes,
   output logic [1:0]              o_gnt,
   output logic [DATA_DEPTH-1:0]   o_rsp_bits,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [1:0]              o_done,
   output logic [1:0]              o_err,
   output logic                    o_start,
   output logic [DATA_DEPTH-1:0]   o_addr_bits,
   output logic                    o_addr_valid,
   input  logic                    i_addr_ready,
   output logic [DATA_DEPTH-1:0]   o_nbytes_bits,
   output logic                    o_nbytes_valid,
   input  logic                    i_nbytes_ready,
   output logic [DATA_DEPTH-1:0]   o_data_bits,
   output logic                    o_data_valid,
   input  logic                    i_data_ready,
   input  logic [DATA_DEPTH-1:0]   i_data_bits,
   input  logic                    i_data_valid,
   output logic                    o_data_ready,
   input  logic                    i_nak
);
   state_t state, next;
   logic [1:0] arb_gnt, gnt_q;
   logic own, beat, hold, timeout, xfer;
   logic [DATA_DEPTH-1:0] addr_q, wdata_q, nbytes_q, cnt;
   logic [TIMEOUT_BITS-1:0] wd;

   rr_arbiter2 u_arb (.clk(i_clk), .rst(i_rst), .req(i_req), .take(state == S_IDLE), .gnt(arb_gnt));

   assign beat = state == S_RDATA && i_data_valid && i_rsp_ready;
   // requester backpressure on a pending read byte freezes the watchdog
   assign hold = state == S_RDATA && i_data_valid && !i_rsp_ready;
   assign timeout = wd == TIMEOUT_BITS'(TIMEOUT_LIMIT - 1) && !hold && !beat;
   assign xfer = state inside {S_ADDR, S_NBYTES, S_WDATA, S_RDATA};

   always_comb begin
      next = state;
      case (state)
         S_IDLE:   next = |arb_gnt ? S_GRANT : S_IDLE;
         S_GRANT:  next = S_START;
         S_START:  next = S_ADDR;
         S_ADDR:   next = !i_addr_ready ? S_ADDR : addr_q[RW_BIT] ? S_NBYTES : S_WDATA;
         S_NBYTES: next = i_nbytes_ready ? S_RDATA : S_NBYTES;
         S_WDATA:  next = i_data_ready ? S_DONE : S_WDATA;
         S_RDATA:  next = beat && cnt == '0 ? S_DONE : S_RDATA;
         default:  next = S_IDLE;
      endcase
      // NAK wins over a handshake completing in the same cycle
      if (xfer && (i_nak || (timeout && next == state))) next = S_ERR;
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state    <= S_IDLE;
         gnt_q    <= '0;
         own      <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         nbytes_q <= '0;
         cnt      <= '0;
         wd       <= '0;
      end else begin
         state <= next;
         if (state == S_IDLE && |arb_gnt) begin
            own      <= arb_gnt[1];
            addr_q   <= arb_gnt[1] ? i_req_addr[2*DATA_DEPTH-1:DATA_DEPTH] : i_req_addr[DATA_DEPTH-1:0];
            wdata_q  <= arb_gnt[1] ? i_req_wdata[2*DATA_DEPTH-1:DATA_DEPTH] : i_req_wdata[DATA_DEPTH-1:0];
            nbytes_q <= arb_gnt[1] ? i_req_nbytes[2*DATA_DEPTH-1:DATA_DEPTH] : i_req_nbytes[DATA_DEPTH-1:0];
         end
         if (state == S_GRANT) gnt_q <= onehot(own);
         else if (state == S_DONE || state == S_ERR) gnt_q <= '0;
         if (state == S_NBYTES) cnt <= nbytes_q;
         else if (beat) cnt <= cnt - 1'b1;
         wd <= (state == S_IDLE || next != state || beat) ? '0 : hold ? wd : wd + 1'b1;
      end

   assign o_gnt          = gnt_q;
   assign o_start        = state == S_START;
   assign o_addr_valid   = state == S_ADDR;
   assign o_addr_bits    = addr_q;
   assign o_nbytes_valid = state == S_NBYTES;
   assign o_nbytes_bits  = nbytes_q;
   assign o_data_valid   = state == S_WDATA;
   assign o_data_bits    = wdata_q;
   assign o_rsp_valid    = state == S_RDATA && i_data_valid;
   assign o_rsp_bits     = state == S_RDATA ? i_data_bits : '0;
   assign o_data_ready   = state == S_RDATA && i_rsp_ready;
   assign o_done         = state == S_DONE ? gnt_q : '0;
   assign o_err          = state == S_ERR ? gnt_q : '0;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: randomized scenarios against a transaction-level model of the arbiter.
module tb_i2c_txn_arbiter;
   localparam int TL = 16;
   logic clk = 1'b0, rst;
   always #5 clk = ~clk;

   logic [1:0] i_req, o_gnt, o_done, o_err;
   logic [15:0] i_req_addr, i_req_wdata, i_req_nbytes;
   logic [7:0] o_rsp_bits, o_addr_bits, o_nbytes_bits, o_data_bits, i_data_bits;
   logic o_rsp_valid, i_rsp_ready, o_start, o_addr_valid, i_addr_ready, o_nbytes_valid;
   logic i_nbytes_ready, o_data_valid, i_data_ready, i_data_valid, o_data_ready, i_nak;

   i2c_txn_arbiter #(.DATA_DEPTH(8), .TIMEOUT_LIMIT(TL), .TIMEOUT_BITS(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .i_req_nbytes(i_req_nbytes), .o_gnt(o_gnt), .o_rsp_bits(o_rsp_bits), .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready), .o_done(o_done), .o_err(o_err), .o_start(o_start),
      .o_addr_bits(o_addr_bits), .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
      .o_nbytes_bits(o_nbytes_bits), .o_nbytes_valid(o_nbytes_valid), .i_nbytes_ready(i_nbytes_ready),
      .o_data_bits(o_data_bits), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .i_data_bits(i_data_bits), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_nak(i_nak));

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, lat = 0, aw = 0, nw = 0, dw = 0, starts, done_cnt, err_cnt, ovl = 0;
   int rsp_mode = 0, rsp_hold = 0, addr_first, err_cyc, nak_cyc, prio_m = 0;
   bit rsp_tog = 0, nak_arm = 0, addr_block = 0, keep_req = 0;
   logic [1:0] done_ev, err_ev, prev_gnt = 0;
   logic [7:0] rd_q[$], exp_q[$], addr_seen[$], nb_seen[$], wd_seen[$], rsp_seen[$];
   logic [1:0] gnt_log[$];

   // Round-robin reference: a lone requester wins; on contention the priority holder wins.
   task automatic pick(input logic [1:0] req, output int w);
      w = (req == 2'b11) ? prio_m : (req[1] ? 1 : 0);
      prio_m = 1 - w;
   endtask

   task automatic set_desc(input int r, input logic [7:0] a, input logic [7:0] w, input logic [7:0] n);
      i_req_addr[r*8 +: 8] = a;
      i_req_wdata[r*8 +: 8] = w;
      i_req_nbytes[r*8 +: 8] = n;
   endtask

   task automatic clear_obs();
      addr_seen.delete(); nb_seen.delete(); wd_seen.delete(); rsp_seen.delete();
      gnt_log.delete(); rd_q.delete(); exp_q.delete();
      starts = 0; done_cnt = 0; err_cnt = 0; done_ev = 0; err_ev = 0;
      addr_first = -1; err_cyc = -1; nak_cyc = -1;
   endtask

   // One clock of the bench acting as master and requesters.
   task automatic step();
      @(negedge clk);
      aw = o_addr_valid ? aw + 1 : 0;
      nw = o_nbytes_valid ? nw + 1 : 0;
      dw = o_data_valid ? dw + 1 : 0;
      i_addr_ready = o_addr_valid && !addr_block && aw > lat;
      i_nbytes_ready = o_nbytes_valid && nw > lat;
      i_data_ready = o_data_valid && dw > lat;
      i_data_valid = rd_q.size() > 0;
      i_data_bits = rd_q.size() > 0 ? rd_q[0] : 8'h00;
      rsp_tog = !rsp_tog;
      i_rsp_ready = rsp_mode == 0 ? 1'b1 : rsp_mode == 1 ? rsp_tog : (rsp_hold == 0);
      i_nak = nak_arm && o_addr_valid && aw >= 2;
      if (i_nak) nak_arm = 0;
      #1;
      cyc++;
      if (i_nak) nak_cyc = cyc;
      if (o_start) starts++;
      if (o_addr_valid && addr_first < 0) addr_first = cyc;
      if (o_addr_valid && i_addr_ready) addr_seen.push_back(o_addr_bits);
      if (o_nbytes_valid && i_nbytes_ready) nb_seen.push_back(o_nbytes_bits);
      if (o_data_valid && i_data_ready) wd_seen.push_back(o_data_bits);
      if (o_rsp_valid && i_rsp_ready) begin
         rsp_seen.push_back(o_rsp_bits);
         void'(rd_q.pop_front());
      end
      if (|o_done) begin done_ev = o_done; done_cnt++; end
      if (|o_err) begin err_ev = o_err; err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
      if (!$onehot0(o_gnt)) ovl++;
      if (o_gnt != 0 && prev_gnt == 0) gnt_log.push_back(o_gnt);
      prev_gnt = o_gnt;
      if (!keep_req) i_req = i_req & ~(o_done | o_err);
      if (rsp_hold > 0 && o_rsp_valid) rsp_hold--;
   endtask

   task automatic run_txn(input int budget, input string name);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (|o_done || |o_err) begin ok = 1; break; end
      end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL %s completion: got none within %0d cycles, want done/err pulse", name, budget); end
   endtask

   task automatic test_reset();
      i_req = 2'b01;
      repeat (2) @(negedge clk);
      n_cmp++; if (o_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", o_gnt); end
      n_cmp++; if ({o_start, o_addr_valid, o_nbytes_valid, o_data_valid} !== 4'b0) begin n_bad++; $display("FAIL reset_valids: got %b want 0000", {o_start, o_addr_valid, o_nbytes_valid, o_data_valid}); end
      n_cmp++; if ({o_done, o_err, o_rsp_valid, o_data_ready} !== 6'b0) begin n_bad++; $display("FAIL reset_pulses: got %b want 000000", {o_done, o_err, o_rsp_valid, o_data_ready}); end
      n_cmp++; if ({o_addr_bits, o_nbytes_bits, o_data_bits, o_rsp_bits} !== 32'h0) begin n_bad++; $display("FAIL reset_bits: got %h want 0", {o_addr_bits, o_nbytes_bits, o_data_bits, o_rsp_bits}); end
      i_req = 2'b00;
      rst = 0;
   endtask

   task automatic test_write();
      for (int t = 0; t < 5; t++) begin
         int r, w;
         logic [7:0] a, d;
         logic [1:0] exp;
         r = t == 0 ? 0 : int'($urandom_range(1, 0));
         a = t == 0 ? 8'd78 : 8'($urandom) & 8'hFE;
         d = t == 0 ? 8'h04 : 8'($urandom);
         lat = t == 0 ? 3 : int'($urandom_range(4, 0));
         clear_obs();
         set_desc(r, a, d, 8'($urandom));
         i_req = 2'b01 << r;
         pick(i_req, w);
         exp = 2'b01 << w;
         step(); step();
         set_desc(r, ~a, ~d, 8'hFF);
         run_txn(100, "write");
         n_cmp++; if (starts !== 1) begin n_bad++; $display("FAIL write_start[%0d]: got %0d pulses want 1", t, starts); end
         n_cmp++; if (!(addr_seen.size() == 1 && addr_seen[0] === a)) begin n_bad++; $display("FAIL write_addr[%0d]: got n=%0d %h want %h", t, addr_seen.size(), addr_seen[0], a); end
         n_cmp++; if (!(wd_seen.size() == 1 && wd_seen[0] === d && nb_seen.size() == 0)) begin n_bad++; $display("FAIL write_data[%0d]: got n=%0d %h nb=%0d want %h", t, wd_seen.size(), wd_seen[0], nb_seen.size(), d); end
         n_cmp++; if (done_ev !== exp || err_cnt != 0) begin n_bad++; $display("FAIL write_done[%0d]: got %b err=%0d want %b", t, done_ev, err_cnt, exp); end
         n_cmp++; if (!(gnt_log.size() == 1 && gnt_log[0] === exp)) begin n_bad++; $display("FAIL write_gnt[%0d]: got %b want %b", t, gnt_log[0], exp); end
         step();
         n_cmp++; if (o_gnt !== 2'b00) begin n_bad++; $display("FAIL write_gnt_clear[%0d]: got %b want 00", t, o_gnt); end
      end
   endtask

   task automatic test_read();
      for (int t = 0; t < 6; t++) begin
         int r, w, nb, bad;
         logic [7:0] a;
         r = t == 0 ? 1 : int'($urandom_range(1, 0));
         a = t == 0 ? 8'd79 : 8'($urandom) | 8'h01;
         nb = t == 0 ? 1 : t == 5 ? 255 : int'($urandom_range(7, 0));
         lat = int'($urandom_range(3, 0));
         rsp_mode = t == 0 ? 1 : t == 5 ? 0 : int'($urandom_range(1, 0));
         clear_obs();
         for (int i = 0; i <= nb; i++) begin
            logic [7:0] b;
            b = t == 0 ? (i == 0 ? 8'h19 : 8'h80) : 8'($urandom);
            rd_q.push_back(b);
            exp_q.push_back(b);
         end
         set_desc(r, a, 8'($urandom), 8'(nb));
         i_req = 2'b01 << r;
         pick(i_req, w);
         run_txn(700, "read");
         bad = (rsp_seen.size() != exp_q.size()) ? 1 : 0;
         foreach (exp_q[i]) if (i < rsp_seen.size() && rsp_seen[i] !== exp_q[i]) bad++;
         n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL read_bytes[%0d]: got %0d bytes (%0d wrong) want %0d", t, rsp_seen.size(), bad, exp_q.size()); end
         n_cmp++; if (!(nb_seen.size() == 1 && nb_seen[0] === 8'(nb) && wd_seen.size() == 0)) begin n_bad++; $display("FAIL read_nbytes[%0d]: got n=%0d %h want %h", t, nb_seen.size(), nb_seen[0], 8'(nb)); end
         n_cmp++; if (done_ev !== (2'b01 << w) || err_cnt != 0) begin n_bad++; $display("FAIL read_done[%0d]: got %b err=%0d want %b", t, done_ev, err_cnt, 2'b01 << w); end
         step();
      end
      rsp_mode = 0;
   endtask

   task automatic test_contention();
      int w;
      clear_obs();
      lat = 1;
      set_desc(0, 8'h20, 8'hA0, 8'h00);
      set_desc(1, 8'h40, 8'hB0, 8'h00);
      keep_req = 1;
      i_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         pick(2'b11, w);
         run_txn(60, "contend");
         n_cmp++; if (done_ev !== (2'b01 << w)) begin n_bad++; $display("FAIL contend_done[%0d]: got %b want %b", k, done_ev, 2'b01 << w); end
      end
      i_req = 2'b00;
      keep_req = 0;
      step();
      n_cmp++; if (gnt_log.size() != 4 || ovl != 0) begin n_bad++; $display("FAIL contend_grants: got %0d grants %0d overlaps want 4 0", gnt_log.size(), ovl); end
   endtask

   task automatic test_nak();
      int r, w;
      clear_obs();
      r = int'($urandom_range(1, 0));
      lat = 0;
      set_desc(r, 8'h91, 8'h00, 8'h03);
      addr_block = 1;
      nak_arm = 1;
      i_req = 2'b01 << r;
      pick(i_req, w);
      run_txn(60, "nak");
      addr_block = 0;
      n_cmp++; if (err_ev !== (2'b01 << w) || done_cnt != 0) begin n_bad++; $display("FAIL nak_err: got %b done=%0d want %b", err_ev, done_cnt, 2'b01 << w); end
      n_cmp++; if (err_cyc != nak_cyc + 1) begin n_bad++; $display("FAIL nak_latency: got %0d want %0d", err_cyc - nak_cyc, 1); end
      n_cmp++; if (nb_seen.size() != 0) begin n_bad++; $display("FAIL nak_nbytes: got %0d sent want 0", nb_seen.size()); end
      step();
      clear_obs();
      set_desc(r, 8'h90, 8'h5A, 8'h00);
      i_req = 2'b01 << r;
      pick(i_req, w);
      run_txn(60, "after_nak");
      n_cmp++; if (done_ev !== (2'b01 << w) || wd_seen.size() != 1) begin n_bad++; $display("FAIL after_nak: got %b n=%0d want %b", done_ev, wd_seen.size(), 2'b01 << w); end
      step();
   endtask

   task automatic test_timeout();
      int r, w;
      clear_obs();
      r = int'($urandom_range(1, 0));
      set_desc(r, 8'h32, 8'h11, 8'h00);
      addr_block = 1;
      i_req = 2'b01 << r;
      pick(i_req, w);
      run_txn(80, "timeout");
      addr_block = 0;
      n_cmp++; if (err_ev !== (2'b01 << w) || done_cnt != 0) begin n_bad++; $display("FAIL timeout_err: got %b done=%0d want %b", err_ev, done_cnt, 2'b01 << w); end
      n_cmp++; if (err_cyc - addr_first != TL) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - addr_first, TL); end
      step();
      clear_obs();
      rd_q.push_back(8'hC3);
      set_desc(r, 8'h33, 8'h00, 8'h00);
      rsp_mode = 2;
      rsp_hold = 100;
      i_req = 2'b01 << r;
      pick(i_req, w);
      run_txn(300, "stall");
      rsp_mode = 0;
      n_cmp++; if (done_ev !== (2'b01 << w) || err_cnt != 0) begin n_bad++; $display("FAIL stall_no_timeout: got done=%b err=%0d want %b 0", done_ev, err_cnt, 2'b01 << w); end
      n_cmp++; if (!(rsp_seen.size() == 1 && rsp_seen[0] === 8'hC3)) begin n_bad++; $display("FAIL stall_byte: got n=%0d %h want c3", rsp_seen.size(), rsp_seen[0]); end
      step();
   endtask

   task automatic test_reset_mid();
      int r, w;
      bit seen = 0;
      clear_obs();
      r = int'($urandom_range(1, 0));
      for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom));
      set_desc(r, 8'h55, 8'h00, 8'h05);
      rsp_mode = 2;
      rsp_hold = 50;
      i_req = 2'b01 << r;
      pick(i_req, w);
      for (int i = 0; i < 40 && !seen; i++) begin step(); seen = o_rsp_valid; end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_reach: got no rdata want rdata"); end
      rst = 1;
      #1;
      n_cmp++; if ({o_gnt, o_rsp_valid, o_data_ready} !== 4'b0) begin n_bad++; $display("FAIL rstmid_drop: got %b want 0000", {o_gnt, o_rsp_valid, o_data_ready}); end
      i_req = 2'b00;
      rd_q.delete();
      rsp_mode = 0;
      rsp_hold = 0;
      repeat (3) step();
      n_cmp++; if (done_cnt != 0 || err_cnt != 0) begin n_bad++; $display("FAIL rstmid_pulse: got done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
      @(negedge clk);
      rst = 0;
      prio_m = 0;
      clear_obs();
      set_desc(0, 8'h10, 8'h01, 8'h00);
      set_desc(1, 8'h12, 8'h02, 8'h00);
      i_req = 2'b11;
      pick(i_req, w);
      run_txn(60, "rstmid_first");
      n_cmp++; if (done_ev !== (2'b01 << w)) begin n_bad++; $display("FAIL rstmid_prio: got %b want %b", done_ev, 2'b01 << w); end
      step();
      pick(i_req, w);
      run_txn(60, "rstmid_second");
      n_cmp++; if (done_ev !== (2'b01 << w)) begin n_bad++; $display("FAIL rstmid_other: got %b want %b", done_ev, 2'b01 << w); end
      step();
   endtask

   initial begin
      rst = 1;
      {i_req, i_req_addr, i_req_wdata, i_req_nbytes} = '0;
      {i_rsp_ready, i_addr_ready, i_nbytes_ready, i_data_ready, i_data_valid, i_nak} = '0;
      i_data_bits = '0;
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_nak();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end
endmodule
